ddr_reader: RTL and testbench
=============================

Name: ddr_reader

Overview:
- Read-side counterpart of the frame writer: on a trigger, fetches one frame of 256-bit words from DDR over the AXI read-address/read-data channels.
- Buffers fetched words in an internal FIFO and presents them on a valid/ready stream for downstream display/processing logic.
- Single clock domain: ddr_clk. The DDR read-data channel has no rready, so a burst is issued only when FIFO space for the whole burst is already reserved.

Parameters:
- BASE_ADDR, 28'h0000000: DDR address of frame word 0.
- FRAME_WORDS, 1200: 256-bit words per frame, ≥1.
- BURST_LEN, 16: maximum beats per burst, 1..16.
- ADDR_STEP, 8: address increment per 256-bit word.
- FIFO_DEPTH, 64: word FIFO depth, power of 2, ≥ BURST_LEN.

Ports:
- ddr_clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-high.
- trig  in  1  start one frame read; sampled in IDLE only.
- busy  out  1  high from accepted trig until the last word leaves the FIFO.
- frame_done  out  1  one-cycle pulse when the last frame word is consumed downstream.
- err  out  1  sticky rlast-mismatch flag; cleared by rst or an accepted trig.
- axi_araddr  out  28  burst start address.
- axi_arlen  out  4  beats minus 1.
- axi_arready  in  1  address accepted.
- axi_arvalid  out  1  address valid.
- axi_rdata  in  256  read data.
- axi_rvalid  in  1  read beat valid; cannot be back-pressured.
- axi_rlast  in  1  last beat of burst.
- out_data  out  256  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts word.
- out_sof  out  1  high with out_valid on frame word 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; all counters 0.
- FSM state IDLE: on trig=1, go to REQ. Load word_left=FRAME_WORDS, addr=BASE_ADDR, sof_pending=1. Clear err. Set busy.
- FSM state REQ: burst length blen=min(BURST_LEN, word_left). Assert arvalid only when (FIFO_DEPTH − fifo_count) ≥ blen; this reservation is the only flow control on the read-data channel. Drive arlen=blen−1 and araddr=addr. araddr/arlen are held stable while arvalid=1 and arready=0. On arvalid&&arready: deassert arvalid the next cycle, go to DATA.
- FSM state DATA: each rvalid pushes rdata into the FIFO and increments beat_cnt. On a beat with rlast=1:
  - If beat_cnt+1 ≠ blen, set err.
  - addr += blen*ADDR_STEP (28-bit wrap); word_left −= blen.
  - Go to REQ if word_left>0, else DRAIN.
- One outstanding burst only; no new arvalid during DATA.
- FSM state DRAIN: wait for the FIFO to empty, then go to IDLE.
- Read and write of the FIFO may occur in the same cycle; count is unchanged.
- FIFO push is combinational from rvalid. Pop when out_valid&&out_ready. out_data is valid the same cycle out_valid is high (show-ahead FIFO).
- out_sof = out_valid && sof_pending. sof_pending clears on the first pop.
- frame_done pulses the cycle the last frame word is popped. busy falls one cycle later, together with the return to IDLE.
- trig while busy is ignored.
- Overflow is impossible by reservation. Beats beyond the reservation (protocol violation) are dropped and set err.
- rst mid-frame aborts immediately: FIFO flushed, arvalid dropped. In-flight beats arriving after reset release are ignored in IDLE.
- Minimum latency, trig to first out_valid: 2 cycles + DDR read latency.

Optional Feature:
- Macro DDR_READER_LOOP_EN.
- Defined: on reaching DRAIN, go straight to REQ with word_left/addr/sof_pending reloaded. This gives continuous frame-after-frame streaming without trig. frame_done still pulses per frame, and busy stays high until rst.
- Undefined: single frame per trig as above.

Test Plan:
- FRAME_WORDS=40, BURST_LEN=16, BASE_ADDR=0x100, ADDR_STEP=8, out_ready=1 → bursts (araddr, arlen) = (0x100,15), (0x180,15), (0x200,7). 40 words out in order, out_sof on word 0 only, one frame_done pulse, err=0.
- arready held low 5 cycles → araddr/arlen stable throughout; exactly one handshake per burst.
- FIFO_DEPTH=32, out_ready=0 → first burst issued (16 beats). Second burst issued (free=16). Third burst withheld. After 8 pops, third (arlen=7) issues. No data lost.
- rlast asserted on beat 10 of a 16-beat burst → err=1 and stays set. The next trig clears it.
- trig pulsed during DATA → ignored; exactly 40 words, one frame_done.
- rst asserted mid-burst → outputs 0 next edge, FIFO empty. Residual rvalid beats are not output. A following trig reads a clean frame from BASE_ADDR.

Source files
------------

// File: rtl/ddr_reader.sv
`timescale 1ns/1ps
// ddr_reader
// Read-side frame fetcher: on trig, reads FRAME_WORDS 256-bit words from DDR
// starting at BASE_ADDR using AXI read bursts of up to BURST_LEN beats. The
// words are buffered in a show-ahead FIFO and presented on a valid/ready
// output stream with a start-of-frame marker.
//
// Optional feature macro: DDR_READER_LOOP_EN
//   defined   -> frames stream back to back without trig; busy stays high.
//   undefined -> exactly one frame per accepted trig.
//
// Handshake semantics (all channels): a transfer happens on a rising edge of
// ddr_clk where valid and ready are both high. Once a valid is raised it stays
// high, with its payload stable, until the transfer happens. axi_rvalid has
// no ready: every beat is taken the cycle it appears, which is why a burst is
// only requested once FIFO space for the whole burst is free.
module ddr_reader #(
    parameter logic [27:0] BASE_ADDR   = 28'h0000000,
    parameter int          FRAME_WORDS = 1200,
    parameter int          BURST_LEN   = 16,
    parameter int          ADDR_STEP   = 8,
    parameter int          FIFO_DEPTH  = 64
) (
    input  logic          ddr_clk,
    input  logic          rst,
    input  logic          trig,
    output logic          busy,
    output logic          frame_done,
    output logic          err,
    output logic [27:0]   axi_araddr,
    output logic [3:0]    axi_arlen,
    input  logic          axi_arready,
    output logic          axi_arvalid,
    input  logic [255:0]  axi_rdata,
    input  logic          axi_rvalid,
    input  logic          axi_rlast,
    output logic [255:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic [1:0]    dbg_state
);

    // FIFO pointer / occupancy widths; occupancy needs one extra bit for "full".
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    // Word counters must hold FRAME_WORDS itself.
    localparam int WLW = $clog2(FRAME_WORDS + 1);

    localparam logic [WLW-1:0] FRAME_W  = WLW'(FRAME_WORDS);
    localparam logic [WLW-1:0] LAST_IDX = WLW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);

    // FSM encoding (visible on dbg_state).
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     state_q,     state_d;
    logic [WLW-1:0] word_left_q, word_left_d;   // words not yet requested
    logic [27:0]    addr_q,      addr_d;        // next burst start address
    logic [4:0]     beat_cnt_q,  beat_cnt_d;    // beats accepted in this burst
    logic           err_q,       err_d;
    logic [WLW-1:0] pop_idx_q,   pop_idx_d;     // frame index of the FIFO head

    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q,  count_d;
    logic [255:0]   mem [2**AW];

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [4:0]     blen;       // beats in the current/next burst
    logic [CW-1:0]  free;
    logic           space_ok;
    logic           in_window;  // beat still inside the reserved space
    logic           full;
    logic           push;
    logic           pop;

    // Burst length is the smaller of BURST_LEN and what is left of the frame.
    always_comb begin
        if (32'(word_left_q) >= 32'(BURST_LEN)) begin
            blen = 5'(BURST_LEN);
        end else begin
            blen = 5'(word_left_q);
        end
    end

    // FIFO space accounting and push/pop qualification.
    always_comb begin
        free      = DEPTH_C - count_q;
        space_ok  = (free >= CW'(blen));
        full      = (count_q == DEPTH_C);
        in_window = (beat_cnt_q < blen);
        // Beats outside DATA or past the reservation never enter the FIFO.
        push      = (state_q == S_DATA) && axi_rvalid && in_window && !full;
        pop       = out_valid && out_ready;
    end

    // Output decode; AR payload is forced to zero outside REQ.
    always_comb begin
        axi_arvalid = (state_q == S_REQ) && space_ok;
        axi_araddr  = (state_q == S_REQ) ? addr_q : 28'd0;
        axi_arlen   = (state_q == S_REQ) ? 4'(blen - 5'd1) : 4'd0;
        busy        = (state_q != S_IDLE);
        err         = err_q;
        out_valid   = (count_q != '0);
        out_data    = out_valid ? mem[rd_ptr_q] : '0;
        out_sof     = out_valid && (pop_idx_q == '0);
        frame_done  = pop && (pop_idx_q == LAST_IDX);
        dbg_state   = state_q;
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame position of the head word; drives out_sof and frame_done.
    always_comb begin
        pop_idx_d = pop_idx_q;
        if ((state_q == S_IDLE) && trig) begin
            pop_idx_d = '0;
        end else if (pop) begin
            pop_idx_d = (pop_idx_q == LAST_IDX) ? '0 : pop_idx_q + WLW'(1);
        end
    end

    // Frame sequencing FSM: request bursts, collect beats, drain the FIFO.
    always_comb begin
        state_d     = state_q;
        word_left_d = word_left_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                // Late beats of an aborted burst land here and are ignored.
                if (trig) begin
                    state_d     = S_REQ;
                    word_left_d = FRAME_W;
                    addr_d      = BASE_ADDR;
                    err_d       = 1'b0;
                end
            end
            S_REQ: begin
                if (axi_rvalid) begin
                    err_d = 1'b1;
                end
                if (axi_arvalid && axi_arready) begin
                    beat_cnt_d = 5'd0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (push) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                end
                if (axi_rvalid && !push) begin
                    err_d = 1'b1;
                end
                // rlast always closes the burst, even a short or long one,
                // so the frame still advances and the FSM cannot hang.
                if (axi_rvalid && axi_rlast) begin
                    if ((beat_cnt_q + 5'd1) != blen) begin
                        err_d = 1'b1;
                    end
                    addr_d      = addr_q + 28'(32'(blen) * 32'(ADDR_STEP));
                    word_left_d = word_left_q - WLW'(blen);
                    if (word_left_d != '0) begin
                        state_d = S_REQ;
                    end else begin
`ifdef DDR_READER_LOOP_EN
                        state_d     = S_REQ;
                        word_left_d = FRAME_W;
                        addr_d      = BASE_ADDR;
`else
                        state_d     = S_DRAIN;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (axi_rvalid) begin
                    err_d = 1'b1;
                end
                if (count_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts a frame and flushes the FIFO.
    always_ff @(posedge ddr_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_left_q <= '0;
            addr_q      <= 28'd0;
            beat_cnt_q  <= 5'd0;
            err_q       <= 1'b0;
            pop_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            word_left_q <= word_left_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            pop_idx_q   <= pop_idx_d;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because out_data is gated by out_valid.
    always_ff @(posedge ddr_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= axi_rdata;
        end
    end

endmodule

// File: tb/tb_ddr_reader.sv
`timescale 1ns/1ps
// tb_ddr_reader
// Directed bench for ddr_reader with a 40-word frame, 16-beat bursts and a
// 32-word FIFO. A DDR read responder answers each AR handshake with beats whose
// data encodes the word address; a scoreboard queue holds the expected words.
module tb_ddr_reader;

    localparam logic [27:0] BASE  = 28'h0000100;
    localparam int          FW    = 40;
    localparam int          BL    = 16;
    localparam int          STEP  = 8;
    localparam int          DEPTH = 32;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         trig = 1'b0;
    logic         busy, frame_done, err;
    logic [27:0]  axi_araddr;
    logic [3:0]   axi_arlen;
    logic         axi_arready = 1'b0;
    logic         axi_arvalid;
    logic [255:0] axi_rdata = '0;
    logic         axi_rvalid = 1'b0;
    logic         axi_rlast = 1'b0;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_sof;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    ddr_reader #(
        .BASE_ADDR  (BASE),
        .FRAME_WORDS(FW),
        .BURST_LEN  (BL),
        .ADDR_STEP  (STEP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ddr_clk    (clk),
        .rst        (rst),
        .trig       (trig),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .axi_araddr (axi_araddr),
        .axi_arlen  (axi_arlen),
        .axi_arready(axi_arready),
        .axi_arvalid(axi_arvalid),
        .axi_rdata  (axi_rdata),
        .axi_rvalid (axi_rvalid),
        .axi_rlast  (axi_rlast),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .dbg_state  (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        logic [27:0] addr;
        logic [3:0]  len;
    } burst_t;

    typedef struct {
        string name;
        int    ar_hold;
        int    rmode;
        int    exp_words;
        int    exp_fd;
        int    exp_hs;
        logic  exp_err;
    } scen_t;

    burst_t       exp_bursts[$];
    logic [255:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // Responder / sink controls
    int ar_hold    = 0;
    int ar_wait    = 0;
    int rmode      = 1;   // 0: pop_budget, 1: always ready, 2: ready 2 of 3
    int pop_budget = 0;
    int early_last = 0;   // beat number that gets a premature rlast in burst 1
    int cyc        = 0;

    int hs_idx    = 0;
    int out_idx   = 0;
    int words_out = 0;
    int fd_cnt    = 0;
    bit fd_check  = 1'b1;
    bit ar_active = 1'b0;
    logic [27:0] ar_addr_l = '0;
    logic [3:0]  ar_len_l  = '0;

    int          r_lat   = 0;
    int          r_left  = 0;
    int          r_beat  = 0;
    int          r_burst = 0;
    logic [27:0] r_addr  = '0;

    function automatic logic [255:0] data_of(input logic [27:0] a);
        return {8{4'hA, a}};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // DDR responder, sink and per-cycle monitor (drive at negedge, sample +1)
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        axi_arready = axi_arvalid && (ar_wait >= ar_hold);
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        axi_rdata   = '0;
        if (r_left > 0) begin
            if (r_lat > 0) begin
                r_lat--;
            end else begin
                r_beat++;
                axi_rvalid = 1'b1;
                axi_rdata  = data_of(r_addr);
                axi_rlast  = (r_left == 1) || (r_burst == 1 && r_beat == early_last);
                r_left     = axi_rlast ? 0 : r_left - 1;
                r_addr     = r_addr + 28'(STEP);
            end
        end
        out_ready = (rmode == 1) || (rmode == 2 && (cyc % 3) != 0) ||
                    (rmode == 0 && pop_budget > 0);
        #1;
        if (!rst) begin
            if (axi_arvalid) begin
                if (ar_active) begin
                    check("araddr_stable", 256'(axi_araddr), 256'(ar_addr_l));
                    check("arlen_stable", 256'(axi_arlen), 256'(ar_len_l));
                end else begin
                    ar_active = 1'b1;
                    ar_addr_l = axi_araddr;
                    ar_len_l  = axi_arlen;
                end
                if (axi_arready) begin
                    if (hs_idx < exp_bursts.size()) begin
                        check("araddr", 256'(axi_araddr), 256'(exp_bursts[hs_idx].addr));
                        check("arlen", 256'(axi_arlen), 256'(exp_bursts[hs_idx].len));
                    end else begin
                        check("extra_burst", 256'(hs_idx), 256'(exp_bursts.size()));
                    end
                    hs_idx++;
                    ar_active = 1'b0;
                    ar_wait   = 0;
                    r_addr    = axi_araddr;
                    r_left    = int'(axi_arlen) + 1;
                    r_lat     = 2;
                    r_beat    = 0;
                    r_burst   = hs_idx;
                end else begin
                    ar_wait++;
                end
            end
            check("out_sof", 256'(out_sof), 256'(out_valid && out_idx == 0));
            if (fd_check) begin
                check("frame_done", 256'(frame_done),
                      256'(out_valid && out_ready && out_idx == FW - 1));
            end
            if (frame_done) fd_cnt++;
            if (out_valid && out_ready) begin
                check("word_expected", 256'(exp_q.size() > 0), 256'(1));
                if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
                words_out++;
                out_idx++;
                if (rmode == 0 && pop_budget > 0) pop_budget--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic load_bursts();
        exp_bursts.delete();
        exp_bursts.push_back('{addr: 28'h100, len: 4'd15});
        exp_bursts.push_back('{addr: 28'h180, len: 4'd15});
        exp_bursts.push_back('{addr: 28'h200, len: 4'd7});
        hs_idx = 0;
    endtask

    // Expected words of a frame, leaving out indices [skip_lo, skip_hi).
    task automatic load_words(input int skip_lo, input int skip_hi);
        exp_q.delete();
        for (int i = 0; i < FW; i++) begin
            if (!(i >= skip_lo && i < skip_hi)) exp_q.push_back(data_of(BASE + 28'(i * STEP)));
        end
    endtask

    task automatic start_frame();
        out_idx   = 0;
        words_out = 0;
        fd_cnt    = 0;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({name, "_idle_timeout"}, 256'(busy), 256'(0));
    endtask

    task automatic end_checks(input string name, input int exp_words, input int exp_fd,
                              input int exp_hs, input logic exp_err);
        check({name, "_words"}, 256'(words_out), 256'(exp_words));
        check({name, "_frame_done_cnt"}, 256'(fd_cnt), 256'(exp_fd));
        check({name, "_err"}, 256'(err), 256'(exp_err));
        check({name, "_bursts"}, 256'(hs_idx), 256'(exp_hs));
        check({name, "_leftover"}, 256'(exp_q.size()), 256'(0));
    endtask

    task automatic wait_budget_spent(input int limit);
        int n = 0;
        while (pop_budget > 0 && n < limit) begin
            step();
            n++;
        end
        check("bp_pop_budget_timeout", 256'(pop_budget), 256'(0));
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        scen_t scen [3];
        int    n;

        scen[0] = '{name: "basic",    ar_hold: 0, rmode: 1, exp_words: FW, exp_fd: 1, exp_hs: 3, exp_err: 1'b0};
        scen[1] = '{name: "arhold5",  ar_hold: 5, rmode: 1, exp_words: FW, exp_fd: 1, exp_hs: 3, exp_err: 1'b0};
        scen[2] = '{name: "slowsink", ar_hold: 0, rmode: 2, exp_words: FW, exp_fd: 1, exp_hs: 3, exp_err: 1'b0};

        // Reset state
        step();
        step();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_arvalid", 256'(axi_arvalid), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_state", 256'(dbg_state), 256'(0));
        rst = 1'b0;
        step();

        // Table-driven frames
        for (int s = 0; s < 3; s++) begin
            ar_hold = scen[s].ar_hold;
            rmode   = scen[s].rmode;
            load_bursts();
            load_words(0, 0);
            start_frame();
            wait_idle(scen[s].name, 2000);
            end_checks(scen[s].name, scen[s].exp_words, scen[s].exp_fd, scen[s].exp_hs, scen[s].exp_err);
            step();
        end
        ar_hold = 0;

        // Back-pressure: third burst withheld until 8 words are popped
        rmode      = 0;
        pop_budget = 0;
        load_bursts();
        load_words(0, 0);
        start_frame();
        n = 0;
        while (!(hs_idx == 2 && r_left == 0) && n < 300) begin
            step();
            n++;
        end
        repeat (5) step();
        check("bp_two_bursts", 256'(hs_idx), 256'(2));
        check("bp_arvalid_low", 256'(axi_arvalid), 256'(0));
        check("bp_state_req", 256'(dbg_state), 256'(1));
        check("bp_out_valid", 256'(out_valid), 256'(1));
        pop_budget = 7;
        wait_budget_spent(100);
        repeat (4) step();
        check("bp_withheld_after7", 256'(hs_idx), 256'(2));
        pop_budget = 1;
        wait_budget_spent(100);
        repeat (4) step();
        check("bp_issued_after8", 256'(hs_idx), 256'(3));
        check("bp_words_popped", 256'(words_out), 256'(8));
        rmode = 1;
        wait_idle("bp", 2000);
        end_checks("bp", FW, 1, 3, 1'b0);
        step();

        // Premature rlast on beat 10 of the first burst
        early_last = 10;
        fd_check   = 1'b0;
        load_bursts();
        load_words(10, 16);
        start_frame();
        wait_idle("shortburst", 2000);
        end_checks("shortburst", FW - 6, 0, 3, 1'b1);
        early_last = 0;
        repeat (3) step();
        check("err_sticky", 256'(err), 256'(1));
        fd_check = 1'b1;
        load_bursts();
        load_words(0, 0);
        start_frame();
        check("err_cleared_by_trig", 256'(err), 256'(0));
        wait_idle("after_err", 2000);
        end_checks("after_err", FW, 1, 3, 1'b0);
        step();

        // trig pulsed during DATA is ignored
        load_bursts();
        load_words(0, 0);
        start_frame();
        n = 0;
        while (dbg_state != 2'd2 && n < 100) begin
            step();
            n++;
        end
        check("trigdata_reached_data", 256'(dbg_state), 256'(2));
        trig = 1'b1;
        step();
        trig = 1'b0;
        wait_idle("trigdata", 2000);
        end_checks("trigdata", FW, 1, 3, 1'b0);
        step();

        // Reset mid-burst
        load_bursts();
        load_words(0, 0);
        start_frame();
        n = 0;
        while (words_out < 3 && n < 200) begin
            step();
            n++;
        end
        check("midrst_reached", 256'(words_out >= 3), 256'(1));
        rst = 1'b1;
        #1;
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_arvalid", 256'(axi_arvalid), 256'(0));
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_out_data", out_data, 256'(0));
        check("midrst_sof", 256'(out_sof), 256'(0));
        check("midrst_state", 256'(dbg_state), 256'(0));
        exp_q.delete();
        exp_bursts.delete();
        hs_idx    = 0;
        ar_active = 1'b0;
        ar_wait   = 0;
        step();
        step();
        rst = 1'b0;
        n = 0;
        while (r_left > 0 && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        check("midrst_residual_out_valid", 256'(out_valid), 256'(0));
        check("midrst_residual_busy", 256'(busy), 256'(0));
        check("midrst_residual_err", 256'(err), 256'(0));
        load_bursts();
        load_words(0, 0);
        start_frame();
        wait_idle("postrst", 2000);
        end_checks("postrst", FW, 1, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hang guard
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
